// File: rtl/top_one_pkg.sv
// Shared constants for the top_one real-time clock counter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package top_one_pkg;

  // Bit width of every time field and of the parallel-load data inputs.
  localparam int WIDTH    = 6;

  // Terminal (last legal) value of each field before it wraps to zero.
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

endpackage : top_one_pkg

// File: rtl/top_one_mod_counter.sv
// Modulo-(MAX+1) counter stage with synchronous parallel load, used as one field of the RTC.
// Latency: count updates one clock after en/load; carry_out is combinational.
// Backpressure: none; en qualifies counting, load overrides en.
//
// Ports:
//   clock     - rising-edge clock
//   reset_n   - asynchronous active-low reset, forces count to 0
//   en        - count enable (carry-in from the previous stage)
//   load      - synchronous load strobe, wins over en
//   data      - load value; anything above MAX loads 0
//   count     - registered field value, always within 0..MAX
//   carry_out - en & (count == MAX): this stage wraps on the next edge
module mod_counter #(
  parameter int WIDTH = top_one_pkg::WIDTH,
  parameter int MAX   = top_one_pkg::SEC_MAX
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic             at_max;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_count;

  assign at_max    = (count == MAX_V);
  assign carry_out = en & at_max;

  // Out-of-range load data is replaced by 0 so the field can never leave
  // its legal range, even when upstream hands us garbage.
  assign load_val  = (data > MAX_V) ? '0 : data;

  always_comb begin
    next_count = count;
    if (load) begin
      next_count = load_val;
    end else if (en) begin
      next_count = at_max ? '0 : (count + ONE_V);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

endmodule : mod_counter

// File: rtl/top_one.sv
// Cascaded HH:MM:SS binary real-time counter with parallel load and day-rollover carry.
// Latency: one clock from enable/load to updated count_*; carry_hour is combinational.
// Backpressure: none; enable is a one-second tick qualifier, load overrides enable.
//
// Ports:
//   clock      - rising-edge clock
//   reset_n    - asynchronous active-low reset, clears all fields immediately
//   enable     - advance one second on the next edge
//   load       - load data_sec/data_min/data_hour on the next edge (no count that cycle)
//   data_sec   - seconds load value (>SEC_MAX loads 0)
//   data_min   - minutes load value (>MIN_MAX loads 0)
//   data_hour  - hours load value (>HOUR_MAX loads 0)
//   count_sec  - registered seconds 0..SEC_MAX
//   count_min  - registered minutes 0..MIN_MAX
//   count_hour - registered hours 0..HOUR_MAX
//   carry_hour - high in the cycle before 23:59:59 rolls to 00:00:00
module top_one
  import top_one_pkg::*;
#(
  parameter int WIDTH    = top_one_pkg::WIDTH,
  parameter int SEC_MAX  = top_one_pkg::SEC_MAX,
  parameter int MIN_MAX  = top_one_pkg::MIN_MAX,
  parameter int HOUR_MAX = top_one_pkg::HOUR_MAX
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data_sec,
  input  logic [WIDTH-1:0] data_min,
  input  logic [WIDTH-1:0] data_hour,
  output logic [WIDTH-1:0] count_sec,
  output logic [WIDTH-1:0] count_min,
  output logic [WIDTH-1:0] count_hour,
  output logic             carry_hour
);

  logic sec_carry;
  logic min_carry;
  logic hour_carry;

  // Ripple of enables: each stage only advances when every lower stage is
  // at its terminal value and the tick is present. All stages share the
  // same edge, so a full 23:59:59 wrap happens in one cycle. load is fed to
  // every stage in parallel and overrides the cascaded enables locally.
  mod_counter #(
    .WIDTH (WIDTH),
    .MAX   (SEC_MAX)
  ) u_sec (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (enable),
    .load      (load),
    .data      (data_sec),
    .count     (count_sec),
    .carry_out (sec_carry)
  );

  mod_counter #(
    .WIDTH (WIDTH),
    .MAX   (MIN_MAX)
  ) u_min (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (sec_carry),
    .load      (load),
    .data      (data_min),
    .count     (count_min),
    .carry_out (min_carry)
  );

  mod_counter #(
    .WIDTH (WIDTH),
    .MAX   (HOUR_MAX)
  ) u_hour (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (min_carry),
    .load      (load),
    .data      (data_hour),
    .count     (count_hour),
    .carry_out (hour_carry)
  );

  // The stage carries are not gated by load (load wins inside each stage
  // anyway), so the day carry must be masked here: a load at 23:59:59 is
  // not a rollover. During reset all fields read 0, so this is already 0.
  assign carry_hour = hour_carry & ~load;

endmodule : top_one

// File: tb/tb_top_one.sv
// Directed self-checking bench for top_one.
module tb_top_one;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       load;
  logic [5:0] data_sec;
  logic [5:0] data_min;
  logic [5:0] data_hour;
  logic [5:0] count_sec;
  logic [5:0] count_min;
  logic [5:0] count_hour;
  logic       carry_hour;

  int checks;
  int errors;

  top_one dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .load       (load),
    .data_sec   (data_sec),
    .data_min   (data_min),
    .data_hour  (data_hour),
    .count_sec  (count_sec),
    .count_min  (count_min),
    .count_hour (count_hour),
    .carry_hour (carry_hour)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to one time unit after the next rising edge; inputs are driven
  // and outputs sampled there, well away from the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single-cycle parallel load, enable left at the given level afterwards low.
  task automatic do_load(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    load      = 1'b1;
    enable    = 1'b0;
    data_hour = h;
    data_min  = m;
    data_sec  = s;
    tick();
    load      = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] got;
    reset_n = 1'b0;
    enable  = 1'b0;
    load    = 1'b0;
    data_sec = '0; data_min = '0; data_hour = '0;
    #1;
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== 18'd0 || carry_hour !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: got %0d:%0d:%0d carry=%b, want 0:0:0 carry=0",
               count_hour, count_min, count_sec, carry_hour);
    end
    tick();
    reset_n = 1'b1;
    do_load(6'd5, 6'd10, 6'd19);
    enable = 1'b1;
    tick();
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== {6'd5, 6'd10, 6'd20}) begin
      errors++;
      $display("FAIL reset_precount: got %0d:%0d:%0d, want 5:10:20",
               count_hour, count_min, count_sec);
    end
    // Assert reset between edges: outputs must clear without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== 18'd0 || carry_hour !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got %0d:%0d:%0d carry=%b, want 0:0:0 carry=0",
               count_hour, count_min, count_sec, carry_hour);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== 18'd0 || carry_hour !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got %0d:%0d:%0d carry=%b, want 0:0:0 carry=0",
               count_hour, count_min, count_sec, carry_hour);
    end
    enable  = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_basic_count();
    logic [17:0] got;
    reset_n = 1'b0;
    enable  = 1'b0;
    tick();
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 61; i++) tick();
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== {6'd0, 6'd1, 6'd1}) begin
      errors++;
      $display("FAIL basic_61: got %0d:%0d:%0d, want 0:1:1", count_hour, count_min, count_sec);
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== {6'd0, 6'd1, 6'd1}) begin
      errors++;
      $display("FAIL basic_hold: got %0d:%0d:%0d, want 0:1:1", count_hour, count_min, count_sec);
    end
  endtask

  task automatic test_cascade();
    logic [17:0] got;
    do_load(6'd0, 6'd59, 6'd58);
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== {6'd0, 6'd59, 6'd58}) begin
      errors++;
      $display("FAIL cascade_load: got %0d:%0d:%0d, want 0:59:58", count_hour, count_min, count_sec);
    end
    enable = 1'b1;
    tick();
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== {6'd0, 6'd59, 6'd59} || carry_hour !== 1'b0) begin
      errors++;
      $display("FAIL cascade_59: got %0d:%0d:%0d carry=%b, want 0:59:59 carry=0",
               count_hour, count_min, count_sec, carry_hour);
    end
    tick();
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== {6'd1, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL cascade_hour: got %0d:%0d:%0d, want 1:0:0", count_hour, count_min, count_sec);
    end
    enable = 1'b0;
  endtask

  task automatic test_rollover();
    logic [17:0] got;
    do_load(6'd23, 6'd59, 6'd58);
    enable = 1'b1;
    #1;
    checks++;
    if (carry_hour !== 1'b0) begin
      errors++;
      $display("FAIL roll_carry_early: got carry=%b, want 0", carry_hour);
    end
    tick();
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== {6'd23, 6'd59, 6'd59} || carry_hour !== 1'b1) begin
      errors++;
      $display("FAIL roll_235959: got %0d:%0d:%0d carry=%b, want 23:59:59 carry=1",
               count_hour, count_min, count_sec, carry_hour);
    end
    // Same value with enable low: no carry.
    enable = 1'b0;
    #1;
    checks++;
    if (carry_hour !== 1'b0) begin
      errors++;
      $display("FAIL roll_carry_noen: got carry=%b, want 0", carry_hour);
    end
    enable = 1'b1;
    tick();
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== 18'd0 || carry_hour !== 1'b0) begin
      errors++;
      $display("FAIL roll_wrap: got %0d:%0d:%0d carry=%b, want 0:0:0 carry=0",
               count_hour, count_min, count_sec, carry_hour);
    end
    enable = 1'b0;
  endtask

  task automatic test_load_priority();
    logic [17:0] got;
    do_load(6'd23, 6'd59, 6'd59);
    enable    = 1'b1;
    load      = 1'b1;
    data_hour = 6'd12;
    data_min  = 6'd34;
    data_sec  = 6'd56;
    #1;
    checks++;
    if (carry_hour !== 1'b0) begin
      errors++;
      $display("FAIL prio_carry: got carry=%b, want 0 while load=1 at 23:59:59", carry_hour);
    end
    tick();
    load = 1'b0;
    enable = 1'b0;
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== {6'd12, 6'd34, 6'd56}) begin
      errors++;
      $display("FAIL prio_load: got %0d:%0d:%0d, want 12:34:56", count_hour, count_min, count_sec);
    end
  endtask

  task automatic test_out_of_range();
    logic [17:0] got;
    do_load(6'd30, 6'd60, 6'd63);
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== 18'd0) begin
      errors++;
      $display("FAIL oor_all: got %0d:%0d:%0d, want 0:0:0", count_hour, count_min, count_sec);
    end
    do_load(6'd23, 6'd45, 6'd59);
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== {6'd23, 6'd45, 6'd59}) begin
      errors++;
      $display("FAIL oor_legal: got %0d:%0d:%0d, want 23:45:59", count_hour, count_min, count_sec);
    end
    // Only the offending field is cleared.
    do_load(6'd5, 6'd60, 6'd10);
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== {6'd5, 6'd0, 6'd10}) begin
      errors++;
      $display("FAIL oor_min_only: got %0d:%0d:%0d, want 5:0:10", count_hour, count_min, count_sec);
    end
    do_load(6'd24, 6'd0, 6'd60);
    checks++;
    got = {count_hour, count_min, count_sec};
    if (got !== 18'd0) begin
      errors++;
      $display("FAIL oor_edge: got %0d:%0d:%0d, want 0:0:0", count_hour, count_min, count_sec);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    enable  = 1'b0;
    load    = 1'b0;
    data_sec = '0; data_min = '0; data_hour = '0;
    test_reset();
    test_basic_count();
    test_cascade();
    test_rollover();
    test_load_priority();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_top_one
